// File: rtl/gf_mul_seq.sv
// gf_mul_seq: iterative GF(2^WIDTH) multiplier, LANES lanes under one controller.
//
// Each lane runs an interleaved shift-and-add multiply: per step the
// multiplicand is conditionally folded into the accumulator, then advanced by
// xtime, while the multiplier shifts right.  STEPS steps are chained per BUSY
// cycle, so an operation takes N = WIDTH/STEPS BUSY cycles regardless of data.
// STEPS must divide WIDTH.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands valid          in_ready   block can accept operands
//   in_a       LANES*WIDTH multiplicands, lane i at [i*WIDTH +: WIDTH]
//   in_b       LANES*WIDTH multipliers, same packing
//   out_valid  products valid          out_ready  consumer accepts products
//   out_p      LANES*WIDTH products, same packing

module gf_mul_lane #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY = 8'h1B,
    parameter int              STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,     // capture operands, clear accumulator
    input  logic             step,     // perform STEPS multiply steps
    input  logic             last,     // final BUSY cycle: publish product
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);
    logic [WIDTH-1:0] a_reg, b_reg, acc;
    logic [WIDTH-1:0] a_nxt, b_nxt, acc_nxt;

    // STEPS chained shift-and-add steps within one cycle.
    always_comb begin
        a_nxt   = a_reg;
        b_nxt   = b_reg;
        acc_nxt = acc;
        for (int s = 0; s < STEPS; s++) begin
            if (b_nxt[0])
                acc_nxt = acc_nxt ^ a_nxt;
            a_nxt = {a_nxt[WIDTH-2:0], 1'b0} ^ (a_nxt[WIDTH-1] ? POLY : '0);
            b_nxt = b_nxt >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            p     <= '0;
        end else if (load) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
        end else if (step) begin
            a_reg <= a_nxt;
            b_reg <= b_nxt;
            acc   <= acc_nxt;
            // The product is taken from this cycle's result so out_p is
            // ready on the same edge out_valid rises.
            if (last)
                p <= acc_nxt;
        end
    end
endmodule

module gf_mul_seq #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY = 8'h1B,
    parameter int              STEPS = 1,
    parameter int              LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_p
);
    localparam int N  = WIDTH / STEPS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          load, step, last;

    // in_ready is only ever high in IDLE, so it doubles as the accept qualifier.
    assign load = (state == IDLE) && in_valid;
    assign step = (state == BUSY);
    assign last = step && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= BUSY;
                        cnt      <= CW'(N);
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gf_mul_lane #(
            .WIDTH (WIDTH),
            .POLY  (POLY),
            .STEPS (STEPS)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .step (step),
            .last (last),
            .a    (in_a[i*WIDTH +: WIDTH]),
            .b    (in_b[i*WIDTH +: WIDTH]),
            .p    (out_p[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_gf_mul_seq.sv
module tb_gf_mul_seq;
    localparam int NOPS = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, iv_aux, out_ready;
    logic [31:0] in_a, in_b;
    logic        in_ready, out_valid;
    logic [31:0] out_p;
    logic        in_ready2, out_valid2, in_ready8, out_valid8;
    logic [31:0] out_p2, out_p8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gf_mul_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p)
    );
    gf_mul_seq #(.STEPS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv_aux), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid2),
        .out_ready(out_ready), .out_p(out_p2)
    );
    gf_mul_seq #(.STEPS(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv_aux), .in_ready(in_ready8),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid8),
        .out_ready(out_ready), .out_p(out_p8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: carry-less polynomial product, then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] vmul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        for (int l = 0; l < 4; l++)
            r[l*8 +: 8] = gmul(a[l*8 +: 8], b[l*8 +: 8]);
        return r;
    endfunction

    // One operation on the default DUT, checking latency, product and release.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int k = 0;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1'b1);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (out_valid) break;
        end
        chk({tag, "_lat"}, k, 8);
        chk({tag, "_p"}, out_p, exp);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    function automatic logic [7:0] rbyte();
        return ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    endfunction

    initial begin
        logic [31:0] held;
        logic [31:0] q[$];
        int k2, k8, nacc, acc_cyc, cyc;
        logic ov_prev;

        rst = 1'b1; in_valid = 1'b0; iv_aux = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {in_ready, out_valid, out_p}, {1'b1, 1'b0, 32'h0});
        @(negedge clk); rst = 1'b0;

        // FIPS-197 vectors and identity / inverse / zero.
        run_op("fips", 32'h802F5757, 32'h02021383, 32'h1B5EFEC1);
        run_op("ident", 32'hFF000153, 32'h00FFA7CA, 32'h0000A701);

        // STEPS=2 and STEPS=8 builds on the FIPS vectors.
        @(negedge clk);
        in_a = 32'h802F5757; in_b = 32'h02021383; iv_aux = 1'b1;
        @(posedge clk); #1;
        iv_aux = 1'b0;
        k2 = 0; k8 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_valid2 && k2 == 0) k2 = c;
            if (out_valid8 && k8 == 0) k8 = c;
        end
        chk("s2_lat", k2, 4);
        chk("s8_lat", k8, 1);
        chk("s2_p", out_p2, 32'h1B5EFEC1);
        chk("s8_p", out_p8, 32'h1B5EFEC1);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("aux_idle", {in_ready2, in_ready8, out_valid2, out_valid8}, 4'b1100);

        // Backpressure: product held, in_valid pulses ignored.
        @(negedge clk);
        in_a = 32'h0302010E; in_b = 32'h090B0D0E; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        held = vmul(32'h0302010E, 32'h090B0D0E);
        chk("bp_first", {out_valid, out_p}, {1'b1, held});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0]; in_a = $urandom; in_b = $urandom;
            @(posedge clk); #1;
            chk("bp_hold", {in_ready, out_valid, out_p}, {1'b0, 1'b1, held});
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", {in_ready, out_valid}, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_after", {in_ready, out_valid, out_p}, {1'b1, 1'b0, held});

        // Reset three edges into BUSY.
        @(negedge clk);
        in_a = 32'h11223344; in_b = 32'h55667788; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid", {in_ready, out_valid, out_p}, {1'b1, 1'b0, 32'h0});
        @(negedge clk); rst = 1'b0;
        run_op("post_rst", 32'h57575757, 32'h83838383, 32'hC1C1C1C1);

        // Random regression with in-order scoreboard.
        nacc = 0; acc_cyc = 0; ov_prev = 1'b0; cyc = 0;
        while ((nacc < NOPS || q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            if (out_valid && !ov_prev)
                chk("rand_lat", cyc - 1 - acc_cyc, 8);
            ov_prev = out_valid;
            in_a = {rbyte(), rbyte(), rbyte(), rbyte()};
            in_b = {rbyte(), rbyte(), rbyte(), rbyte()};
            in_valid = (nacc < NOPS) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                q.push_back(vmul(in_a, in_b));
                nacc++;
                acc_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rand_spurious", 1'b1, 1'b0);
                else chk("rand_p", out_p, q.pop_front());
            end
            cyc++;
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        chk("rand_drain", q.size(), 0);
        chk("rand_count", nacc, NOPS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
